four12_arb: RTL and testbench

FOUR12_ARB -- requirements
Module: four12_arb

---
 rtl/four12_pkg.sv | 42 ++++
 rtl/four12_dsp.sv | 76 +++++++
 rtl/four12_arb.sv | 104 ++++++++++
 tb/tb_four12_arb.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/four12_pkg.sv
// four12_pkg: shared constants, types and lane helpers for the
// four-lane 12-bit SIMD add arbiter (four12_arb) and its DSP (four12_dsp).
package four12_pkg;

   localparam int LANE_W = 12;
   localparam int LANES  = 4;
   localparam int NREQ   = 2;
   localparam int DATA_W = LANE_W * LANES;

   // DSP multiplexer selections, modelled on the DSP48 OPMODE fields
   typedef enum logic [1:0] {
      X_ZERO = 2'b00,
      X_AB   = 2'b11
   } x_sel_e;

   typedef enum logic [1:0] {
      Y_ZERO = 2'b00,
      Y_ONES = 2'b10
   } y_sel_e;

   typedef enum logic [2:0] {
      Z_ZERO = 3'b000,
      Z_C    = 3'b011
   } z_sel_e;

   // Fixed configuration of the single DSP instance: P = Z + Y + X
   localparam x_sel_e X_SEL = X_AB;
   localparam y_sel_e Y_SEL = Y_ZERO;
   localparam z_sel_e Z_SEL = Z_C;

   // Tag that travels alongside the data through the DSP registers
   typedef struct packed {
      logic v;
      logic id;
   } tag_t;

   // Lowest bit of lane k inside a packed 48-bit word
   function automatic int lane_lo(input int k);
      return k * LANE_W;
   endfunction

endpackage

// File: rtl/four12_dsp.sv
// four12_dsp: behavioural model of one DSP slice in FOUR12 SIMD mode.
// Ports: clk_i; rst_ab_i/rst_c_i/rst_p_i sync active-high resets;
//        ce_ab_i/ce_c_i/ce_p_i clock enables; ab_i, c_i 48-bit operands;
//        p_o 48-bit lane sums; carry_o per-lane carry out.
module four12_dsp
   import four12_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_ab_i,
   input  logic              rst_c_i,
   input  logic              rst_p_i,
   input  logic              ce_ab_i,
   input  logic              ce_c_i,
   input  logic              ce_p_i,
   input  logic [DATA_W-1:0] ab_i,
   input  logic [DATA_W-1:0] c_i,
   output logic [DATA_W-1:0] p_o,
   output logic [LANES-1:0]  carry_o
);

   logic [DATA_W-1:0] ab_r;
   logic [DATA_W-1:0] c_r;
   logic [DATA_W-1:0] x_mux;
   logic [DATA_W-1:0] y_mux;
   logic [DATA_W-1:0] z_mux;
   logic [DATA_W-1:0] p_d;
   logic [LANES-1:0]  co_d;

   // Input registers: reset has priority over the clock enable
   always_ff @(posedge clk_i) begin
      if (rst_ab_i) begin
         ab_r <= '0;
      end else if (ce_ab_i) begin
         ab_r <= ab_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_c_i) begin
         c_r <= '0;
      end else if (ce_c_i) begin
         c_r <= c_i;
      end
   end

   always_comb begin
      x_mux = '0;
      y_mux = '0;
      z_mux = '0;
      if (X_SEL == X_AB) x_mux = ab_r;
      if (Y_SEL == Y_ONES) y_mux = '1;
      if (Z_SEL == Z_C) z_mux = c_r;
   end

   // Each lane adds on its own; the 13th bit of every lane sum is
   // that lane's carry and never feeds the next lane.
   for (genvar k = 0; k < LANES; k++) begin : g_lane
      logic [LANE_W:0] sum;
      assign sum = {1'b0, z_mux[lane_lo(k) +: LANE_W]}
                 + {1'b0, y_mux[lane_lo(k) +: LANE_W]}
                 + {1'b0, x_mux[lane_lo(k) +: LANE_W]};
      assign p_d[lane_lo(k) +: LANE_W] = sum[LANE_W-1:0];
      assign co_d[k] = sum[LANE_W];
   end

   always_ff @(posedge clk_i) begin
      if (rst_p_i) begin
         p_o     <= '0;
         carry_o <= '0;
      end else if (ce_p_i) begin
         p_o     <= p_d;
         carry_o <= co_d;
      end
   end

endmodule

// File: rtl/four12_arb.sv
// four12_arb: two-requester round-robin front end for a FOUR12 DSP add.
// Ports: clk_i, rst_n_i (sync, active-low); req_valid_i/req_ready_o and
//        req_ab_i/req_c_i (2x48, requester k at [48k+47:48k]);
//        rsp_valid_o/rsp_ready_i, rsp_id_o, rsp_data_o, rsp_carry_o.
module four12_arb
   import four12_pkg::*;
(
   input  logic                   clk_i,
   input  logic                   rst_n_i,
   input  logic [NREQ-1:0]        req_valid_i,
   output logic [NREQ-1:0]        req_ready_o,
   input  logic [NREQ*DATA_W-1:0] req_ab_i,
   input  logic [NREQ*DATA_W-1:0] req_c_i,
   output logic                   rsp_valid_o,
   input  logic                   rsp_ready_i,
   output logic                   rsp_id_o,
   output logic [DATA_W-1:0]      rsp_data_o,
   output logic [LANES-1:0]       rsp_carry_o
);

   logic              stall;
   logic              ce;
   logic              dsp_rst;
   logic [NREQ-1:0]   grant;
   logic              last_grant;
   logic              accept;
   logic              acc_id;
   logic [DATA_W-1:0] ab_sel;
   logic [DATA_W-1:0] c_sel;
   logic [DATA_W-1:0] ab_d;
   logic [DATA_W-1:0] c_d;
   tag_t              s1;
   tag_t              s2;

   // Only a valid result that is not taken can block the pipe
   assign stall   = s2.v & ~rsp_ready_i;
   assign ce      = ~stall;
   assign dsp_rst = ~rst_n_i;

   // Contention goes to the requester that did not win last time
   always_comb begin
      grant = '0;
      unique case (req_valid_i)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = last_grant ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

   assign req_ready_o = (rst_n_i && !stall) ? grant : 2'b00;
   assign accept      = |req_ready_o;
   assign acc_id      = req_ready_o[1];

   assign ab_sel = acc_id ? req_ab_i[DATA_W +: DATA_W]
                          : req_ab_i[0 +: DATA_W];
   assign c_sel  = acc_id ? req_c_i[DATA_W +: DATA_W]
                          : req_c_i[0 +: DATA_W];

   // Idle cycles feed zeros so P settles to zero behind a bubble
   assign ab_d = accept ? ab_sel : '0;
   assign c_d  = accept ? c_sel  : '0;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         s1         <= '0;
         s2         <= '0;
         last_grant <= 1'b1;
      end else begin
         if (accept) begin
            last_grant <= acc_id;
         end
         if (ce) begin
            s1.v  <= accept;
            s1.id <= acc_id;
            s2    <= s1;
         end
      end
   end

   four12_dsp u_dsp (
      .clk_i    (clk_i),
      .rst_ab_i (dsp_rst),
      .rst_c_i  (dsp_rst),
      .rst_p_i  (dsp_rst),
      .ce_ab_i  (ce),
      .ce_c_i   (ce),
      .ce_p_i   (ce),
      .ab_i     (ab_d),
      .c_i      (c_d),
      .p_o      (rsp_data_o),
      .carry_o  (rsp_carry_o)
   );

   assign rsp_valid_o = s2.v;
   assign rsp_id_o    = s2.id;

   a_one_ready : assert property (
      @(posedge clk_i) req_ready_o != 2'b11);

   a_no_ready_in_stall : assert property (
      @(posedge clk_i) stall |-> req_ready_o == 2'b00);

endmodule

// File: tb/tb_four12_arb.sv
// tb_four12_arb: table vectors, directed corner sequences and random
// traffic for four12_arb, checked against a lane-arithmetic model.
module tb_four12_arb;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [95:0] req_ab;
   logic [95:0] req_c;
   logic        rsp_valid;
   logic        rsp_ready;
   logic        rsp_id;
   logic [47:0] rsp_data;
   logic [3:0]  rsp_carry;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   four12_arb dut (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready),
      .req_ab_i    (req_ab),
      .req_c_i     (req_c),
      .rsp_valid_o (rsp_valid),
      .rsp_ready_i (rsp_ready),
      .rsp_id_o    (rsp_id),
      .rsp_data_o  (rsp_data),
      .rsp_carry_o (rsp_carry)
   );

   // Reference: an in-flight item is its id plus its lane sums,
   // computed with plain integer arithmetic.
   typedef struct {
      logic        v;
      logic        id;
      logic [47:0] d;
      logic [3:0]  c;
   } item_t;

   item_t m_s1;
   item_t m_s2;
   logic  m_last;

   function automatic item_t mk(input logic id, input logic [47:0] ab,
                                input logic [47:0] c);
      item_t r;
      r.v  = 1'b1;
      r.id = id;
      r.d  = '0;
      r.c  = '0;
      for (int k = 0; k < 4; k++) begin
         int s;
         s = int'(ab[12*k +: 12]) + int'(c[12*k +: 12]);
         r.d[12*k +: 12] = 12'(s % 4096);
         r.c[k] = (s >= 4096);
      end
      return r;
   endfunction

   function automatic item_t empty_item();
      item_t r;
      r.v  = 1'b0;
      r.id = 1'b0;
      r.d  = '0;
      r.c  = '0;
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // One clock: apply valids/ready, check ready, clock, check outputs
   task automatic step(input logic [1:0] v, input logic rdy,
                       output logic [1:0] gr);
      logic       stall;
      logic [1:0] g;
      logic       id;
      req_valid = v;
      rsp_ready = rdy;
      #1;
      stall = m_s2.v & ~rdy;
      case (v)
         2'b01:   g = 2'b01;
         2'b10:   g = 2'b10;
         2'b11:   g = m_last ? 2'b01 : 2'b10;
         default: g = 2'b00;
      endcase
      gr = (stall || !rst_n) ? 2'b00 : g;
      chk("req_ready", 64'(req_ready), 64'(gr));
      id = gr[1];
      @(posedge clk);
      if (!rst_n) begin
         m_s1   = empty_item();
         m_s2   = empty_item();
         m_last = 1'b1;
      end else begin
         if (!stall) begin
            m_s2 = m_s1;
            if (|gr) m_s1 = mk(id, req_ab[48*id +: 48], req_c[48*id +: 48]);
            else     m_s1 = empty_item();
         end
         if (|gr) m_last = id;
      end
      #1;
      chk("rsp_valid", 64'(rsp_valid), 64'(m_s2.v));
      if (m_s2.v) begin
         chk("rsp_id", 64'(rsp_id), 64'(m_s2.id));
         chk("rsp_data", 64'(rsp_data), 64'(m_s2.d));
         chk("rsp_carry", 64'(rsp_carry), 64'(m_s2.c));
      end
   endtask

   typedef struct {
      logic        id;
      logic [47:0] ab;
      logic [47:0] c;
      logic [47:0] exp_d;
      logic [3:0]  exp_c;
   } vec_t;

   vec_t vecs[6];

   initial begin
      logic [1:0] gr;

      vecs[0] = '{1'b0, 48'h001002003004, 48'h010020030040,
                  48'h011022033044, 4'b0000};
      vecs[1] = '{1'b1, 48'hFFF800000FFF, 48'h001800000000,
                  48'h000000000FFF, 4'b1100};
      vecs[2] = '{1'b0, 48'hFFFFFFFFFFFF, 48'hFFFFFFFFFFFF,
                  48'hFFEFFEFFEFFE, 4'b1111};
      vecs[3] = '{1'b1, 48'h123456789ABC, 48'h111111111111,
                  48'h23456789ABCD, 4'b0000};
      vecs[4] = '{1'b0, 48'h000000000000, 48'h000000000000,
                  48'h000000000000, 4'b0000};
      vecs[5] = '{1'b1, 48'h7FF001FFF800, 48'h801FFF001800,
                  48'h000000000000, 4'b1111};

      rst_n     = 1'b0;
      req_valid = '0;
      rsp_ready = 1'b1;
      req_ab    = '0;
      req_c     = '0;
      m_s1      = empty_item();
      m_s2      = empty_item();
      m_last    = 1'b1;

      @(posedge clk);
      #1;
      step(2'b11, 1'b1, gr);
      chk("reset_ready", 64'(req_ready), 64'(0));
      chk("reset_valid", 64'(rsp_valid), 64'(0));
      chk("reset_id", 64'(rsp_id), 64'(0));
      chk("reset_data", 64'(rsp_data), 64'(0));
      chk("reset_carry", 64'(rsp_carry), 64'(0));
      rst_n = 1'b1;

      // Single requests: result two edges after being presented
      for (int i = 0; i < 6; i++) begin
         req_ab = {$urandom, $urandom, $urandom};
         req_c  = {$urandom, $urandom, $urandom};
         req_ab[48*vecs[i].id +: 48] = vecs[i].ab;
         req_c[48*vecs[i].id +: 48]  = vecs[i].c;
         step(2'b01 << vecs[i].id, 1'b1, gr);
         step(2'b00, 1'b1, gr);
         chk("vec_valid", 64'(rsp_valid), 64'(1));
         chk("vec_id", 64'(rsp_id), 64'(vecs[i].id));
         chk("vec_data", 64'(rsp_data), 64'(vecs[i].exp_d));
         chk("vec_carry", 64'(rsp_carry), 64'(vecs[i].exp_c));
         step(2'b00, 1'b1, gr);
      end

      // Continuous contention after reset alternates 0,1,0,1
      rst_n = 1'b0;
      step(2'b00, 1'b1, gr);
      rst_n = 1'b1;
      for (int k = 0; k < 8; k++) begin
         req_ab = {$urandom, $urandom, $urandom};
         req_c  = {$urandom, $urandom, $urandom};
         step(2'b11, 1'b1, gr);
         chk("rr_grant", 64'(gr), 64'((k % 2 == 0) ? 2'b01 : 2'b10));
         if (k >= 1) begin
            chk("rr_rsp_valid", 64'(rsp_valid), 64'(1));
            chk("rr_rsp_id", 64'(rsp_id), 64'((k - 1) % 2));
         end
      end
      step(2'b00, 1'b1, gr);
      chk("rr_last_id", 64'(rsp_id), 64'(1));
      step(2'b00, 1'b1, gr);

      // Backpressure with a full pipeline
      req_ab = {$urandom, $urandom, $urandom};
      req_c  = {$urandom, $urandom, $urandom};
      step(2'b01, 1'b1, gr);
      step(2'b10, 1'b1, gr);
      for (int k = 0; k < 3; k++) begin
         step(2'b11, 1'b0, gr);
         chk("stall_ready", 64'(req_ready), 64'(0));
         chk("stall_id", 64'(rsp_id), 64'(0));
         chk("stall_data", 64'(rsp_data),
             64'(mk(1'b0, req_ab[47:0], req_c[47:0]).d));
      end
      step(2'b00, 1'b1, gr);
      chk("release_id", 64'(rsp_id), 64'(1));
      chk("release_data", 64'(rsp_data),
          64'(mk(1'b1, req_ab[95:48], req_c[95:48]).d));
      step(2'b00, 1'b1, gr);
      chk("release_drained", 64'(rsp_valid), 64'(0));

      // Reset with two results in flight
      step(2'b01, 1'b1, gr);
      step(2'b10, 1'b1, gr);
      rst_n = 1'b0;
      step(2'b11, 1'b1, gr);
      chk("midrst_valid", 64'(rsp_valid), 64'(0));
      rst_n = 1'b1;
      step(2'b00, 1'b1, gr);
      chk("midrst_stale1", 64'(rsp_valid), 64'(0));
      step(2'b00, 1'b1, gr);
      chk("midrst_stale2", 64'(rsp_valid), 64'(0));
      step(2'b11, 1'b1, gr);
      chk("midrst_grant", 64'(gr), 64'(2'b01));
      step(2'b00, 1'b1, gr);
      step(2'b00, 1'b1, gr);

      // Random traffic on every channel
      for (int i = 0; i < 10000; i++) begin
         req_ab = {$urandom, $urandom, $urandom};
         req_c  = {$urandom, $urandom, $urandom};
         step(2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0), gr);
      end
      for (int i = 0; i < 4; i++) step(2'b00, 1'b1, gr);
      chk("final_empty", 64'(rsp_valid), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
